// File: rtl/axi_data_mem_slave.sv
// AXI-style data-memory responder behind the data cache.
// Word-addressed SRAM; fixed-length INCR reads, wlast-terminated writes.
module axi_data_mem_slave #(
  parameter int    ADDR_W     = 32,
  parameter int    DEPTH_LOG2 = 12,
  parameter int    RD_BEATS   = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  input  logic [31:0]       axi_wdata,
  input  logic [3:0]        axi_wstrb,
  input  logic              axi_wlast,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  input  logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  output logic [31:0]       axi_rdata,
  output logic              axi_rlast
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RD_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    WRESP,
    RREAD,
    RDATA
  } state_e;

  state_e                state_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [BW-1:0]         beat_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [31:0]           rdata_q;

  logic [31:0] mem [DEPTH];

  logic                  aw_hs;
  logic                  ar_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  r_hs;
  logic [DEPTH_LOG2-1:0] aw_idx;
  logic [DEPTH_LOG2-1:0] ar_idx;
  logic [DEPTH_LOG2-1:0] idx_inc;
  logic [BW-1:0]         beat_inc;

  assign aw_idx   = axi_awaddr[DEPTH_LOG2+1:2];
  assign ar_idx   = axi_araddr[DEPTH_LOG2+1:2];
  assign idx_inc  = idx_q + 1'b1;
  assign beat_inc = beat_q + 1'b1;

  // awready_q doubles as the "idle and accepting" flag; writes win ties
  assign axi_awready = awready_q;
  assign axi_arready = awready_q & ~axi_awvalid;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rlast   = rlast_q;
  assign axi_rdata   = rdata_q;

  assign aw_hs = awready_q & axi_awvalid;
  assign ar_hs = axi_arready & axi_arvalid;
  assign w_hs  = wready_q & axi_wvalid;
  assign b_hs  = bvalid_q & axi_bready;
  assign r_hs  = rvalid_q & axi_rready;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_awaddr[ADDR_W-1:DEPTH_LOG2+2],
                              axi_awaddr[1:0],
                              axi_araddr[ADDR_W-1:DEPTH_LOG2+2],
                              axi_araddr[1:0]};

  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (axi_wstrb[b]) mem[idx_q][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      beat_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            idx_q     <= aw_idx;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            state_q   <= WDATA;
          end else if (ar_hs) begin
            idx_q     <= ar_idx;
            beat_q    <= '0;
            awready_q <= 1'b0;
            state_q   <= RREAD;
          end
        end
        WDATA: begin
          if (w_hs) begin
            idx_q <= idx_inc;
            if (axi_wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              state_q  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (b_hs) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        RREAD: begin
          rdata_q  <= mem[idx_q];
          rvalid_q <= 1'b1;
          rlast_q  <= (beat_q == LAST_BEAT);
          state_q  <= RDATA;
        end
        RDATA: begin
          if (r_hs) begin
            if (beat_q == LAST_BEAT) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              awready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              // next word fetched now so beats can go back to back
              beat_q  <= beat_inc;
              idx_q   <= idx_inc;
              rdata_q <= mem[idx_inc];
              rlast_q <= (beat_inc == LAST_BEAT);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
